// File: rtl/duel_arena_if.sv
// duel_arena_if: game controls and display/status outputs for the duel arena
interface duel_arena_if #(parameter int N = 8);
  localparam int W = $clog2(N);
  logic tick, scan_tick;
  logic [3:0] a_move, b_move;
  logic a_attack, a_defense, b_attack, b_defense;
  logic [W-1:0] a_row, a_col, b_row, b_col, scan_col;
  logic [3:0] a_life, b_life;
  logic [1:0] state;
  logic [N-1:0] R_color, G_color, B_color;
  modport master (
    output tick, scan_tick, a_move, b_move, a_attack, a_defense, b_attack, b_defense,
    input a_row, a_col, b_row, b_col, a_life, b_life, state, scan_col, R_color, G_color, B_color
  );
  modport slave (
    input tick, scan_tick, a_move, b_move, a_attack, a_defense, b_attack, b_defense,
    output a_row, a_col, b_row, b_col, a_life, b_life, state, scan_col, R_color, G_color, B_color
  );
endinterface

// File: rtl/duel_arena.sv
// duel_arena: two-player grid duel with vertical volleys and a column-scanned RGB display
module duel_arena #(
  parameter int N = 8,
  parameter int LIVES = 4,
  parameter int COOLDOWN = 3
) (
  input logic CLK,
  input logic Clear,
  duel_arena_if.slave dif
);
  localparam int W = $clog2(N);
  typedef enum logic [1:0] {PLAY, A_WIN, B_WIN, DRAW} st_t;
  st_t st, nst;
  logic [1:0][W-1:0] pr, pc, tr, tc, nr, nc;
  logic [1:0][3:0] mv, lf, nlf, cd, ncd;
  logic [1:0] atk, dfn, df, blk, fire, hit;
  logic [1:0][1:0] bv, nbv;
  logic [1:0][1:0][W-1:0] br, bc, nbr, nbc;
  logic [W-1:0] sc, nsc;
  logic [N-1:0] rc, gc, bcl, nrc, ngc, nbcl;
  function automatic logic [W-1:0] step(input logic [W-1:0] p, input logic dec, input logic inc);
    return dec ? (p == '0 ? p : p - 1'b1) : inc ? (p == W'(N - 1) ? p : p + 1'b1) : p;
  endfunction
  assign mv = {dif.b_move, dif.a_move};
  assign atk = {dif.b_attack, dif.a_attack};
  assign dfn = {dif.b_defense, dif.a_defense};
  // index 0 is player A, 1 is player B; bullet index 0 flies up, 1 flies down
  always_comb begin
    hit = '0;
    for (int p = 0; p < 2; p++) begin
      tr[p] = step(pr[p], mv[p][3], mv[p][2]);
      tc[p] = step(pc[p], mv[p][1], mv[p][0]);
    end
    for (int p = 0; p < 2; p++) begin
      blk[p] = {tr[p], tc[p]} == {pr[1-p], pc[1-p]} || {tr[0], tc[0]} == {tr[1], tc[1]};
      nr[p] = blk[p] ? pr[p] : tr[p];
      nc[p] = blk[p] ? pc[p] : tc[p];
      fire[p] = atk[p] && !dfn[p] && bv[p] == 2'b00 && cd[p] == '0;
      ncd[p] = fire[p] ? 4'(COOLDOWN) : cd[p] - 4'(cd[p] != '0);
      nbv[p][0] = fire[p] ? nr[p] != '0 : bv[p][0] && br[p][0] != '0;
      nbv[p][1] = fire[p] ? nr[p] != W'(N - 1) : bv[p][1] && br[p][1] != W'(N - 1);
      nbr[p][0] = (fire[p] ? nr[p] : br[p][0]) - 1'b1;
      nbr[p][1] = (fire[p] ? nr[p] : br[p][1]) + 1'b1;
      nbc[p][0] = fire[p] ? nc[p] : bc[p][0];
      nbc[p][1] = fire[p] ? nc[p] : bc[p][1];
    end
    for (int p = 0; p < 2; p++)
      for (int d = 0; d < 2; d++)
        if (nbv[p][d] && nbr[p][d] == nr[1-p] && nbc[p][d] == nc[1-p]) begin
          nbv[p][d] = 1'b0;
          hit[1-p] = 1'b1;
        end
    for (int p = 0; p < 2; p++)
      nlf[p] = lf[p] - 4'(hit[p] && !dfn[p] && lf[p] != '0);
    nst = nlf[0] == '0 && nlf[1] == '0 ? DRAW : nlf[1] == '0 ? A_WIN : nlf[0] == '0 ? B_WIN : PLAY;
  end
  // masks are built for the column that becomes current on this scan_tick
  always_comb begin
    nsc = sc == W'(N - 1) ? '0 : sc + 1'b1;
    nrc = st == A_WIN ? '0 : '1;
    ngc = st == B_WIN ? '0 : '1;
    nbcl = st == DRAW ? '0 : '1;
    if (st == PLAY) begin
      if (pc[0] == nsc) nrc[pr[0]] = 1'b0;
      if (pc[1] == nsc) ngc[pr[1]] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (pc[p] == nsc && df[p]) begin
          nrc[pr[p]] = 1'b0;
          ngc[pr[p]] = 1'b0;
          nbcl[pr[p]] = 1'b0;
        end
        for (int d = 0; d < 2; d++)
          if (bv[p][d] && bc[p][d] == nsc) nbcl[br[p][d]] = 1'b0;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (Clear) begin
      st <= PLAY;
      pr <= {W'(N - 1), W'(0)};
      pc <= {2{W'(N / 2)}};
      lf <= {2{4'(LIVES)}};
      cd <= '0;
      df <= '0;
      bv <= '0;
      br <= '0;
      bc <= '0;
      sc <= '0;
      rc <= '1;
      gc <= '1;
      bcl <= '1;
    end else begin
      if (dif.tick && st == PLAY) begin
        st <= nst;
        pr <= nr;
        pc <= nc;
        lf <= nlf;
        cd <= ncd;
        df <= dfn;
        bv <= nbv;
        br <= nbr;
        bc <= nbc;
      end
      if (dif.scan_tick) begin
        sc <= nsc;
        rc <= nrc;
        gc <= ngc;
        bcl <= nbcl;
      end
    end
  end
  assign dif.a_row = pr[0];
  assign dif.a_col = pc[0];
  assign dif.b_row = pr[1];
  assign dif.b_col = pc[1];
  assign dif.a_life = lf[0];
  assign dif.b_life = lf[1];
  assign dif.state = st;
  assign dif.scan_col = sc;
  assign dif.R_color = rc;
  assign dif.G_color = gc;
  assign dif.B_color = bcl;
endmodule

// File: tb/tb_duel_arena.sv
// tb_duel_arena: directed duel scenarios on a 4-life and a 1-life arena checked against a rule model
module tb_duel_arena;
  localparam int N = 8;
  localparam int W = $clog2(N);
  localparam int COOL = 3;
  logic clk = 0;
  always #5 clk = ~clk;
  logic clr = 1, tick = 0, scan = 0, aa = 0, ad = 0, ba = 0, bd = 0;
  logic [3:0] am = 0, bm = 0;
  int checks = 0, errors = 0;
  bit armed = 0;
  duel_arena_if #(.N(N)) i4 ();
  duel_arena_if #(.N(N)) i1 ();
  assign i4.tick = tick;
  assign i4.scan_tick = scan;
  assign i4.a_move = am;
  assign i4.b_move = bm;
  assign i4.a_attack = aa;
  assign i4.a_defense = ad;
  assign i4.b_attack = ba;
  assign i4.b_defense = bd;
  assign i1.tick = tick;
  assign i1.scan_tick = scan;
  assign i1.a_move = am;
  assign i1.b_move = bm;
  assign i1.a_attack = aa;
  assign i1.a_defense = ad;
  assign i1.b_attack = ba;
  assign i1.b_defense = bd;
  duel_arena #(.N(N), .LIVES(4), .COOLDOWN(COOL)) d4 (.CLK(clk), .Clear(clr), .dif(i4.slave));
  duel_arena #(.N(N), .LIVES(1), .COOLDOWN(COOL)) d1 (.CLK(clk), .Clear(clr), .dif(i1.slave));
  // model state per arena k (0: 4 lives, 1: 1 life) and player p (0: A, 1: B)
  int lv[2] = '{4, 1};
  int m_r[2][2], m_c[2][2], m_lf[2][2], m_cd[2][2], m_st[2], m_sc[2];
  bit m_df[2][2];
  bit m_bv[2][2][2];
  int m_br[2][2][2], m_bc[2][2][2];
  logic [N-1:0] m_rm[2], m_gm[2], m_bm[2];
  logic [48:0] got[2], expv;
  function automatic int clampi(input int v);
    return v < 0 ? 0 : v > N - 1 ? N - 1 : v;
  endfunction
  task automatic play_tick(input int k);
    logic [3:0] mv[2];
    bit atk[2], dfn[2], blk[2], hit[2];
    int tr[2], tc[2];
    mv[0] = am; mv[1] = bm;
    atk[0] = aa; atk[1] = ba;
    dfn[0] = ad; dfn[1] = bd;
    hit[0] = 0; hit[1] = 0;
    for (int p = 0; p < 2; p++) begin
      tr[p] = clampi(m_r[k][p] + (mv[p][3] ? -1 : (mv[p][2] ? 1 : 0)));
      tc[p] = clampi(m_c[k][p] + (mv[p][1] ? -1 : (mv[p][0] ? 1 : 0)));
    end
    for (int p = 0; p < 2; p++)
      blk[p] = (tr[p] == m_r[k][1-p] && tc[p] == m_c[k][1-p]) || (tr[0] == tr[1] && tc[0] == tc[1]);
    for (int p = 0; p < 2; p++)
      if (!blk[p]) begin
        m_r[k][p] = tr[p];
        m_c[k][p] = tc[p];
      end
    for (int p = 0; p < 2; p++) begin
      if (atk[p] && !dfn[p] && !m_bv[k][p][0] && !m_bv[k][p][1] && m_cd[k][p] == 0) begin
        m_cd[k][p] = COOL;
        for (int d = 0; d < 2; d++) begin
          m_br[k][p][d] = m_r[k][p] + (d == 1 ? 1 : -1);
          m_bc[k][p][d] = m_c[k][p];
          m_bv[k][p][d] = m_br[k][p][d] >= 0 && m_br[k][p][d] < N;
        end
      end else begin
        if (m_cd[k][p] > 0) m_cd[k][p]--;
        for (int d = 0; d < 2; d++)
          if (m_bv[k][p][d]) begin
            m_br[k][p][d] += (d == 1 ? 1 : -1);
            if (m_br[k][p][d] < 0 || m_br[k][p][d] >= N) m_bv[k][p][d] = 0;
          end
      end
    end
    for (int p = 0; p < 2; p++)
      for (int d = 0; d < 2; d++)
        if (m_bv[k][p][d] && m_br[k][p][d] == m_r[k][1-p] && m_bc[k][p][d] == m_c[k][1-p]) begin
          m_bv[k][p][d] = 0;
          hit[1-p] = 1;
        end
    for (int p = 0; p < 2; p++) begin
      if (hit[p] && !dfn[p] && m_lf[k][p] > 0) m_lf[k][p]--;
      m_df[k][p] = dfn[p];
    end
    m_st[k] = (m_lf[k][0] == 0 && m_lf[k][1] == 0) ? 3 : (m_lf[k][1] == 0) ? 1 : (m_lf[k][0] == 0) ? 2 : 0;
  endtask
  task automatic model_step(input int k);
    int col;
    logic [N-1:0] r, g, b;
    if (clr) begin
      m_r[k][0] = 0; m_r[k][1] = N - 1;
      m_c[k][0] = N / 2; m_c[k][1] = N / 2;
      for (int p = 0; p < 2; p++) begin
        m_lf[k][p] = lv[k];
        m_cd[k][p] = 0;
        m_df[k][p] = 0;
        for (int d = 0; d < 2; d++) m_bv[k][p][d] = 0;
      end
      m_st[k] = 0; m_sc[k] = 0;
      m_rm[k] = '1; m_gm[k] = '1; m_bm[k] = '1;
    end else begin
      if (scan) begin
        col = (m_sc[k] + 1) % N;
        r = '1; g = '1; b = '1;
        if (m_st[k] == 0) begin
          for (int p = 0; p < 2; p++)
            if (m_c[k][p] == col) begin
              if (p == 0) r[m_r[k][p]] = 0; else g[m_r[k][p]] = 0;
              if (m_df[k][p]) begin
                r[m_r[k][p]] = 0; g[m_r[k][p]] = 0; b[m_r[k][p]] = 0;
              end
            end
          for (int p = 0; p < 2; p++)
            for (int d = 0; d < 2; d++)
              if (m_bv[k][p][d] && m_bc[k][p][d] == col) b[m_br[k][p][d]] = 0;
        end else begin
          if (m_st[k] == 1) r = '0;
          if (m_st[k] == 2) g = '0;
          if (m_st[k] == 3) b = '0;
        end
        m_rm[k] = r; m_gm[k] = g; m_bm[k] = b;
        m_sc[k] = col;
      end
      if (tick && m_st[k] == 0) play_tick(k);
    end
  endtask
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    if (clr) armed = 1;
  end
  always @(negedge clk) if (armed) begin
    got[0] = {i4.a_row, i4.a_col, i4.b_row, i4.b_col, i4.a_life, i4.b_life, i4.state, i4.scan_col, i4.R_color, i4.G_color, i4.B_color};
    got[1] = {i1.a_row, i1.a_col, i1.b_row, i1.b_col, i1.a_life, i1.b_life, i1.state, i1.scan_col, i1.R_color, i1.G_color, i1.B_color};
    for (int k = 0; k < 2; k++) begin
      expv = {W'(m_r[k][0]), W'(m_c[k][0]), W'(m_r[k][1]), W'(m_c[k][1]), 4'(m_lf[k][0]), 4'(m_lf[k][1]),
              2'(m_st[k]), W'(m_sc[k]), m_rm[k], m_gm[k], m_bm[k]};
      checks++;
      if (got[k] !== expv) begin
        errors++;
        $display("FAIL model_cmp arena%0d t=%0t got %h exp %h", k, $time, got[k], expv);
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask
  task automatic pulse(input logic t, input logic s);
    tick = t; scan = s;
    @(posedge clk); #2;
    tick = 0; scan = 0;
  endtask
  task automatic do_clear();
    clr = 1; pulse(0, 0); clr = 0;
  endtask
  task automatic scan_to(input int c);
    do pulse(0, 1); while (m_sc[0] != c);
  endtask
  initial begin
    do_clear();
    chk("rst_a_row", i4.a_row, 0);
    chk("rst_b_row", i4.b_row, 7);
    chk("rst_a_col", i4.a_col, 4);
    chk("rst_b_col", i4.b_col, 4);
    chk("rst_a_life", i4.a_life, 4);
    chk("rst_a_life1", i1.a_life, 1);
    chk("rst_state", i4.state, 0);
    chk("rst_R", i4.R_color, 8'hFF);
    repeat (4) pulse(0, 1);
    chk("disp_col", i4.scan_col, 4);
    chk("disp_R", i4.R_color, 8'hFE);
    chk("disp_G", i4.G_color, 8'h7F);
    chk("disp_B", i4.B_color, 8'hFF);
    am = 4'b1000;
    repeat (3) pulse(1, 0);
    chk("sat_a_row", i4.a_row, 0);
    am = 0; bm = 4'b1000;
    repeat (10) pulse(1, 0);
    chk("block_b_row", i4.b_row, 1);
    chk("block_b_col", i4.b_col, 4);
    bm = 0; ad = 1;
    pulse(1, 0);
    ad = 0;
    scan_to(4);
    chk("white_R", i4.R_color, 8'hFE);
    chk("white_G", i4.G_color, 8'hFC);
    chk("white_B", i4.B_color, 8'hFE);
    do_clear();
    bm = 4'b1000;
    repeat (2) pulse(1, 0);
    bm = 0;
    chk("b_row5", i4.b_row, 5);
    aa = 1; pulse(1, 0); aa = 0;
    scan_to(4);
    chk("bullet_B", i4.B_color, 8'hFD);
    chk("bullet_G", i4.G_color, 8'hDF);
    repeat (3) pulse(1, 0);
    chk("pre_hit_life", i4.b_life, 4);
    pulse(1, 0);
    chk("hit_life", i4.b_life, 3);
    scan_to(4);
    chk("consumed_B", i4.B_color, 8'hFF);
    do_clear();
    bm = 4'b1000;
    repeat (2) pulse(1, 0);
    bm = 0; bd = 1; aa = 1;
    repeat (5) pulse(1, 0);
    chk("def_life", i4.b_life, 4);
    scan_to(4);
    chk("def_R", i4.R_color, 8'hDE);
    chk("cool_B", i4.B_color, 8'hDF);
    pulse(1, 0);
    scan_to(4);
    chk("refire_B", i4.B_color, 8'hDD);
    chk("refire_life", i4.b_life, 4);
    aa = 0; bd = 0;
    do_clear();
    bm = 4'b1000;
    repeat (2) pulse(1, 0);
    bm = 0;
    aa = 1; pulse(1, 0); aa = 0;
    repeat (4) pulse(1, 0);
    chk("awin_state", i1.state, 1);
    chk("awin_b_life", i1.b_life, 0);
    chk("awin_d4_life", i4.b_life, 3);
    chk("awin_d4_state", i4.state, 0);
    am = 4'b0100;
    repeat (2) pulse(1, 0);
    am = 0;
    chk("frozen_a_row", i1.a_row, 0);
    chk("moving_a_row", i4.a_row, 2);
    for (int c = 0; c < N; c++) begin
      pulse(0, 1);
      chk("awin_R", i1.R_color, 8'h00);
      chk("awin_G", i1.G_color, 8'hFF);
    end
    clr = 1; pulse(1, 1); clr = 0;
    chk("clr_state", i1.state, 0);
    chk("clr_a_life", i1.a_life, 1);
    chk("clr_b_life", i1.b_life, 1);
    chk("clr_scan", i1.scan_col, 0);
    chk("clr_R", i1.R_color, 8'hFF);
    aa = 1; ba = 1; pulse(1, 0); aa = 0; ba = 0;
    repeat (5) pulse(1, 0);
    chk("pre_draw", i1.state, 0);
    pulse(1, 0);
    chk("draw_state", i1.state, 3);
    chk("draw_a_life", i1.a_life, 0);
    chk("draw_b_life", i1.b_life, 0);
    chk("draw_d4_a", i4.a_life, 3);
    chk("draw_d4_b", i4.b_life, 3);
    for (int c = 0; c < N; c++) begin
      pulse(0, 1);
      chk("draw_B", i1.B_color, 8'h00);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
